// File: rtl/point_cloud_loader_pkg.sv
// Shared definitions for the point cloud loader: FSM encoding and BRAM header layout.
package point_cloud_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_HEADER,
    ST_DONE
  } state_e;

  localparam int BRAM_WIDTH = 128;
  localparam int BRAM_BYTES = BRAM_WIDTH / 8;

  localparam logic [31:0]           HEADER_ADDR  = 32'd0;
  localparam logic [31:0]           HEADER_VALID = 32'd1;
  localparam logic [BRAM_BYTES-1:0] HEADER_WE    = 16'h000F;

  function automatic logic [BRAM_WIDTH-1:0] header_word(input logic [31:0] value);
    return {{(BRAM_WIDTH - 32){1'b0}}, value};
  endfunction

endpackage

// File: rtl/point_cloud_loader_lane_packer.sv
// Per-axis lane register: collects up to LANES coordinates into one BRAM word
// and tracks which lanes hold data so partial words get a matching byte mask.
module lane_packer
  import point_cloud_loader_pkg::*;
#(
  parameter int N     = 16,
  parameter int LANES = 8,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [LW-1:0]         lane_i,
  input  logic [N-1:0]          data_i,
  output logic [BRAM_WIDTH-1:0] word_o,
  output logic [BRAM_BYTES-1:0] mask_o
);

  localparam int BPL = BRAM_BYTES / LANES;

  logic [LANES-1:0][N-1:0] lanes_q, lanes_d;
  logic [LANES-1:0]        filled_q, filled_d;

  // Clear and load may coincide: the first point of a new cloud lands in a fresh word.
  always_comb begin
    lanes_d  = clear_i ? '0 : lanes_q;
    filled_d = clear_i ? '0 : filled_q;
    if (load_i) begin
      lanes_d[lane_i]  = data_i;
      filled_d[lane_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lanes_q  <= '0;
      filled_q <= '0;
    end else begin
      lanes_q  <= lanes_d;
      filled_q <= filled_d;
    end
  end

  assign word_o = BRAM_WIDTH'(lanes_q);

  for (genvar b = 0; b < BRAM_BYTES; b++) begin : g_mask
    assign mask_o[b] = filled_q[b / BPL];
  end

endmodule

// File: rtl/point_cloud_loader.sv
// Streams x/y/z points into three 128-bit BRAMs, one word per LANES points,
// then writes a header word (point count, valid flag, cleared consumer flag) at address 0.
module point_cloud_loader
  import point_cloud_loader_pkg::*;
#(
  parameter int N         = 16,
  parameter int LANES     = 8,
  parameter int MAX_WORDS = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_last_i,
  input  logic [N-1:0]          in_x_i,
  input  logic [N-1:0]          in_y_i,
  input  logic [N-1:0]          in_z_i,
  output logic [31:0]           addr_x_o,
  output logic [BRAM_WIDTH-1:0] write_in_x_o,
  output logic                  en_x_o,
  output logic                  rst_x_o,
  output logic [BRAM_BYTES-1:0] we_x_o,
  output logic [31:0]           addr_y_o,
  output logic [BRAM_WIDTH-1:0] write_in_y_o,
  output logic                  en_y_o,
  output logic                  rst_y_o,
  output logic [BRAM_BYTES-1:0] we_y_o,
  output logic [31:0]           addr_z_o,
  output logic [BRAM_WIDTH-1:0] write_in_z_o,
  output logic                  en_z_o,
  output logic                  rst_z_o,
  output logic [BRAM_BYTES-1:0] we_z_o,
  output logic                  load_done_o,
  output logic                  overflow_o
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  state_e          state_q, state_d;
  logic [31:0]     count_q, count_d;
  logic [31:0]     wptr_q, wptr_d;
  logic [LW-1:0]   lane_q, lane_d, lane_sel;
  logic            last_q, last_d;
  logic            ovf_q, ovf_d;
  logic            ready, store, clear, wr_ok;

  logic [BRAM_WIDTH-1:0] word_x, word_y, word_z;
  logic [BRAM_BYTES-1:0] mask_x, mask_y, mask_z;

  assign wr_ok = (wptr_q <= 32'(MAX_WORDS));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wptr_d   = wptr_q;
    lane_d   = lane_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    lane_sel = lane_q;
    ready    = 1'b0;
    store    = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (in_valid_i) begin
          clear    = 1'b1;
          store    = 1'b1;
          lane_sel = '0;
          count_d  = 32'd1;
          ovf_d    = 1'b0;
          wptr_d   = 32'd1;
          last_d   = in_last_i;
          if (in_last_i || LANES == 1) begin
            lane_d  = '0;
            state_d = ST_WRITE;
          end else begin
            lane_d  = LW'(1);
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        ready = 1'b1;
        if (in_valid_i) begin
          // Past capacity, points are still consumed so the stream never stalls.
          store  = wr_ok;
          last_d = in_last_i;
          if (wr_ok) count_d = count_q + 32'd1;
          else       ovf_d   = 1'b1;
          if (in_last_i || lane_q == LW'(LANES - 1)) begin
            lane_d  = '0;
            state_d = ST_WRITE;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      ST_WRITE: begin
        wptr_d = wptr_q + 32'd1;
        if (last_q) begin
          state_d = ST_HEADER;
        end else begin
          clear   = 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_HEADER: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wptr_q  <= 32'd1;
      lane_q  <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  lane_packer #(.N(N), .LANES(LANES), .LW(LW)) u_pack_x (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear), .load_i(store),
    .lane_i(lane_sel), .data_i(in_x_i), .word_o(word_x), .mask_o(mask_x)
  );

  lane_packer #(.N(N), .LANES(LANES), .LW(LW)) u_pack_y (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear), .load_i(store),
    .lane_i(lane_sel), .data_i(in_y_i), .word_o(word_y), .mask_o(mask_y)
  );

  lane_packer #(.N(N), .LANES(LANES), .LW(LW)) u_pack_z (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear), .load_i(store),
    .lane_i(lane_sel), .data_i(in_z_i), .word_o(word_z), .mask_o(mask_z)
  );

  // BRAM ports are quiet except during a data word write or the header write.
  always_comb begin
    addr_x_o     = '0;
    addr_y_o     = '0;
    addr_z_o     = '0;
    write_in_x_o = '0;
    write_in_y_o = '0;
    write_in_z_o = '0;
    en_x_o       = 1'b0;
    en_y_o       = 1'b0;
    en_z_o       = 1'b0;
    we_x_o       = '0;
    we_y_o       = '0;
    we_z_o       = '0;
    load_done_o  = 1'b0;
    if (state_q == ST_WRITE && wr_ok) begin
      {en_x_o, en_y_o, en_z_o}       = 3'b111;
      {addr_x_o, addr_y_o, addr_z_o} = {wptr_q, wptr_q, wptr_q};
      write_in_x_o = word_x;
      write_in_y_o = word_y;
      write_in_z_o = word_z;
      we_x_o       = mask_x;
      we_y_o       = mask_y;
      we_z_o       = mask_z;
    end else if (state_q == ST_HEADER) begin
      {en_x_o, en_y_o, en_z_o}       = 3'b111;
      {addr_x_o, addr_y_o, addr_z_o} = {HEADER_ADDR, HEADER_ADDR, HEADER_ADDR};
      write_in_x_o = header_word(count_q);
      write_in_y_o = header_word(HEADER_VALID);
      write_in_z_o = header_word(32'd0);
      {we_x_o, we_y_o, we_z_o} = {HEADER_WE, HEADER_WE, HEADER_WE};
    end else if (state_q == ST_DONE) begin
      load_done_o = 1'b1;
    end
  end

  assign in_ready_o = ready & rst_ni;
  assign overflow_o = ovf_q;
  assign rst_x_o    = 1'b0;
  assign rst_y_o    = 1'b0;
  assign rst_z_o    = 1'b0;

endmodule
